// File: rtl/stream_job_scheduler.sv
// Run-level scheduler: fans job starts out to C_NUM_SRC packet generators and merges their
// packets round-robin onto one AXI4-Stream master. Optional STREAM_SCHED_STALL_CNT_EN adds stall_count.
module stream_job_scheduler #(
   parameter int C_NUM_SRC     = 2,
   parameter int C_TDATA_WIDTH = 128,
   parameter int C_JOB_WIDTH   = 16
) (
   input  logic                               aclk,
   input  logic                               areset,
   input  logic                               ap_start,
   input  logic [C_JOB_WIDTH-1:0]             job_count,
   output logic                               ap_idle,
   output logic                               ap_done,
   output logic [C_NUM_SRC-1:0]               src_start,
   input  logic [C_NUM_SRC-1:0]               s_axis_tvalid,
   output logic [C_NUM_SRC-1:0]               s_axis_tready,
   input  logic [C_NUM_SRC*C_TDATA_WIDTH-1:0] s_axis_tdata,
   input  logic [C_NUM_SRC*C_TDATA_WIDTH/8-1:0] s_axis_tkeep,
   input  logic [C_NUM_SRC-1:0]               s_axis_tlast,
   output logic                               m_axis_tvalid,
   input  logic                               m_axis_tready,
   output logic [C_TDATA_WIDTH-1:0]           m_axis_tdata,
   output logic [C_TDATA_WIDTH/8-1:0]         m_axis_tkeep,
   output logic                               m_axis_tlast
`ifdef STREAM_SCHED_STALL_CNT_EN
   ,
   output logic [31:0]                        stall_count
`endif
);

   localparam int KW = C_TDATA_WIDTH / 8;
   localparam int SW = (C_NUM_SRC > 1) ? $clog2(C_NUM_SRC) : 1;
   localparam logic [C_JOB_WIDTH-1:0] JOB_ONE = 1;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]             state;
   logic                   ap_start_r;
   logic                   go;
   logic [C_JOB_WIDTH-1:0] jobs_total;
   logic [C_JOB_WIDTH-1:0] issued;
   logic [C_JOB_WIDTH-1:0] completed;
   logic [C_JOB_WIDTH-1:0] completed_nxt;
   logic [C_NUM_SRC-1:0]   busy;
   logic [C_NUM_SRC-1:0]   busy_clr;
   logic [C_NUM_SRC-1:0]   start_sel;
   logic                   start_found;
   logic [C_NUM_SRC-1:0]   arb_req;
   logic                   arb_found;
   logic [SW-1:0]          arb_idx;
   int                     cand;
   logic                   locked;
   logic [SW-1:0]          grant;
   logic [SW-1:0]          rr_ptr;
   logic                   tlast_hs;

   assign go      = ap_start & ~ap_start_r;
   assign ap_idle = (state == S_IDLE);
   assign ap_done = (state == S_DONE);
   assign arb_req = s_axis_tvalid & busy;

   // NOTE: every variable written in an always_comb gets a default first, so no path can infer a latch.
   always_comb begin
      start_sel   = '0;
      start_found = 1'b0;
      if (state == S_RUN && issued < jobs_total) begin
         for (int i = 0; i < C_NUM_SRC; i++) begin
            if (!start_found && !busy[i] && !src_start[i]) begin
               start_sel[i] = 1'b1;
               start_found  = 1'b1;
            end
         end
      end
   end

   // Circular search starting just after the last winner.
   always_comb begin
      arb_found = 1'b0;
      arb_idx   = '0;
      cand      = 0;
      for (int k = 1; k <= C_NUM_SRC; k++) begin
         cand = (int'(rr_ptr) + k) % C_NUM_SRC;
         if (!arb_found && arb_req[cand]) begin
            arb_found = 1'b1;
            arb_idx   = SW'(cand);
         end
      end
   end

   always_comb begin
      m_axis_tvalid = 1'b0;
      m_axis_tdata  = '0;
      m_axis_tkeep  = '0;
      m_axis_tlast  = 1'b0;
      s_axis_tready = '0;
      if (locked) begin
         m_axis_tvalid        = s_axis_tvalid[grant];
         m_axis_tdata         = s_axis_tdata[int'(grant)*C_TDATA_WIDTH +: C_TDATA_WIDTH];
         m_axis_tkeep         = s_axis_tkeep[int'(grant)*KW +: KW];
         m_axis_tlast         = s_axis_tlast[grant];
         s_axis_tready[grant] = m_axis_tready;
      end
   end

   assign tlast_hs      = locked & m_axis_tvalid & m_axis_tready & m_axis_tlast;
   assign completed_nxt = completed + C_JOB_WIDTH'(tlast_hs);

   always_comb begin
      busy_clr = '0;
      if (tlast_hs) busy_clr[grant] = 1'b1;
   end

   // NOTE: sequential state uses non-blocking assignments only; reset here is synchronous, active-high.
   always_ff @(posedge aclk) begin
      if (areset) begin
         state      <= S_IDLE;
         ap_start_r <= 1'b0;
         jobs_total <= '0;
         issued     <= '0;
         completed  <= '0;
         busy       <= '0;
         src_start  <= '0;
         locked     <= 1'b0;
         grant      <= '0;
         rr_ptr     <= SW'(C_NUM_SRC - 1);
      end else begin
         ap_start_r <= ap_start;
         src_start  <= start_sel;
         busy       <= (busy & ~busy_clr) | start_sel;
         completed  <= completed_nxt;
         if (|start_sel) issued <= issued + JOB_ONE;

         case (state)
            S_IDLE: begin
               if (go) begin
                  jobs_total <= job_count;
                  issued     <= '0;
                  completed  <= '0;
                  state      <= (job_count == '0) ? S_DONE : S_RUN;
               end
            end
            // Looking at completed_nxt lets ap_done follow the final tlast by one cycle.
            S_RUN:   if (completed_nxt == jobs_total) state <= S_DONE;
            S_DONE:  state <= S_IDLE;
            default: state <= S_IDLE;
         endcase

         if (tlast_hs) begin
            locked <= 1'b0;
         end else if (!locked && state == S_RUN && arb_found) begin
            locked <= 1'b1;
            grant  <= arb_idx;
            rr_ptr <= arb_idx;
         end
      end
   end

`ifdef STREAM_SCHED_STALL_CNT_EN
   always_ff @(posedge aclk) begin
      if (areset) begin
         stall_count <= '0;
      end else if (state == S_IDLE && go) begin
         stall_count <= '0;
      end else if (state == S_RUN && m_axis_tvalid && !m_axis_tready && stall_count != '1) begin
         stall_count <= stall_count + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_stream_job_scheduler.sv
// Self-checking bench for stream_job_scheduler: behavioural packet generators, a master-side
// scoreboard derived from the scheduling rules, and one task per scenario.
module tb_stream_job_scheduler;

   localparam int NSRC = 2;
   localparam int W    = 128;
   localparam int KW   = W / 8;
   localparam int JW   = 16;
   localparam int L    = 4;

   logic               aclk      = 1'b0;
   logic               areset    = 1'b1;
   logic               ap_start  = 1'b0;
   logic [JW-1:0]      job_count = '0;
   logic               ap_idle;
   logic               ap_done;
   logic [NSRC-1:0]    src_start;
   logic [NSRC-1:0]    s_tvalid  = '0;
   logic [NSRC-1:0]    s_tready;
   logic [NSRC*W-1:0]  s_tdata   = '0;
   logic [NSRC*KW-1:0] s_tkeep   = '0;
   logic [NSRC-1:0]    s_tlast   = '0;
   logic               m_tvalid;
   logic               m_tready  = 1'b1;
   logic [W-1:0]       m_tdata;
   logic [KW-1:0]      m_tkeep;
   logic               m_tlast;
`ifdef STREAM_SCHED_STALL_CNT_EN
   logic [31:0]        stall_count;
`endif

   stream_job_scheduler #(.C_NUM_SRC(NSRC), .C_TDATA_WIDTH(W), .C_JOB_WIDTH(JW)) dut (
      .aclk(aclk), .areset(areset), .ap_start(ap_start), .job_count(job_count),
      .ap_idle(ap_idle), .ap_done(ap_done), .src_start(src_start),
      .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready), .s_axis_tdata(s_tdata),
      .s_axis_tkeep(s_tkeep), .s_axis_tlast(s_tlast),
      .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready), .m_axis_tdata(m_tdata),
      .m_axis_tkeep(m_tkeep), .m_axis_tlast(m_tlast)
`ifdef STREAM_SCHED_STALL_CNT_EN
      , .stall_count(stall_count)
`endif
   );

   initial forever #5 aclk = ~aclk;

   int n_checks = 0;
   int n_fail   = 0;
   logic [31:0] salt;

   // Generator state and control knobs
   bit act [NSRC];
   int beat_i [NSRC];
   int seq_i [NSRC];
   bit hs_q [NSRC];
   bit st_q [NSRC];
   bit rst_q = 1'b0;
   bit done_q = 1'b0;
   bit rand_ready = 1'b0;
   int stall_at = -1;
   int stall_left = 0;

   // Scoreboard state
   int cyc = 0;
   int n_starts = 0, exp_pkt = 0, exp_beat = 0, total_beats = 0;
   int done_count = 0, done_cyc = -1, last_hs_cyc = -1, valid_seen = 0, go_cyc = 0;
   bit idle_at_done = 1'b0, idle_after_done = 1'b0, done_after_done = 1'b1;
   int pkt_first [64];
   int pkt_last [64];
   bit prev_stall = 1'b0;
   logic [W-1:0]    prev_data;
   logic [KW-1:0]   prev_keep;
   logic            prev_last;
   logic [NSRC-1:0] exp_oh;

   function automatic logic [W-1:0] data_of(input int src, input int seq, input int beat);
      logic [W-1:0] d;
      for (int w = 0; w < W / 32; w++) d[w*32 +: 32] = salt ^ {8'(src), 8'(seq), 8'(beat), 8'(w)};
      return d;
   endfunction

   function automatic logic [KW-1:0] keep_of(input int seq, input int beat);
      logic [KW-1:0] full;
      full = '1;
      return (beat == L - 1) ? (full >> (seq % 4)) : full;
   endfunction

   // Sources and master ready are driven on the falling edge; everything is sampled 1 time unit later.
   initial begin
      for (int i = 0; i < NSRC; i++) begin
         act[i] = 0; beat_i[i] = 0; seq_i[i] = 0; hs_q[i] = 0; st_q[i] = 0;
      end
      forever begin
         @(negedge aclk);
         for (int i = 0; i < NSRC; i++) begin
            if (rst_q || done_q) seq_i[i] = 0;
            if (rst_q) begin
               act[i] = 0; beat_i[i] = 0;
            end else begin
               if (hs_q[i]) begin
                  if (beat_i[i] == L - 1) begin act[i] = 0; beat_i[i] = 0; seq_i[i]++; end
                  else beat_i[i]++;
               end
               if (st_q[i]) begin act[i] = 1; beat_i[i] = 0; end
            end
            s_tvalid[i]         = act[i];
            s_tdata[i*W +: W]   = act[i] ? data_of(i, seq_i[i], beat_i[i]) : '0;
            s_tkeep[i*KW +: KW] = act[i] ? keep_of(seq_i[i], beat_i[i]) : '0;
            s_tlast[i]          = act[i] && (beat_i[i] == L - 1);
         end
         if (stall_left > 0) begin
            m_tready = 1'b0; stall_left--;
         end else if (stall_at >= 0 && total_beats == stall_at) begin
            stall_at = -1; stall_left = 9; m_tready = 1'b0;
         end else begin
            m_tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
         end

         #1;
         cyc++;
         rst_q  = areset;
         done_q = ap_done;
         for (int i = 0; i < NSRC; i++) begin
            hs_q[i] = s_tvalid[i] & s_tready[i];
            st_q[i] = src_start[i];
         end
         // Starts go to sources in rotation: all free at run start, each restarted as its packet ends.
         if (src_start != '0) begin
            exp_oh = '0;
            exp_oh[n_starts % NSRC] = 1'b1;
            n_checks++;
            if (src_start !== exp_oh) begin
               n_fail++;
               $display("FAIL start_order: start #%0d got %b want %b", n_starts, src_start, exp_oh);
            end
            n_starts++;
         end
         if (m_tvalid) valid_seen++;
         if (prev_stall) begin
            n_checks++;
            if (m_tvalid !== 1'b1 || m_tdata !== prev_data || m_tkeep !== prev_keep || m_tlast !== prev_last) begin
               n_fail++;
               $display("FAIL hold_stable: valid=%b data=%h keep=%h last=%b, required held data=%h keep=%h last=%b",
                        m_tvalid, m_tdata, m_tkeep, m_tlast, prev_data, prev_keep, prev_last);
            end
         end
         if (m_tvalid && m_tready) begin
            n_checks++;
            if (m_tdata !== data_of(exp_pkt % NSRC, exp_pkt / NSRC, exp_beat) ||
                m_tkeep !== keep_of(exp_pkt / NSRC, exp_beat) || m_tlast !== (exp_beat == L - 1)) begin
               n_fail++;
               $display("FAIL beat: pkt %0d beat %0d got data=%h keep=%h last=%b want data=%h keep=%h last=%b",
                        exp_pkt, exp_beat, m_tdata, m_tkeep, m_tlast,
                        data_of(exp_pkt % NSRC, exp_pkt / NSRC, exp_beat), keep_of(exp_pkt / NSRC, exp_beat),
                        exp_beat == L - 1);
            end
            if (exp_beat == 0 && exp_pkt < 64) pkt_first[exp_pkt] = cyc;
            total_beats++;
            if (exp_beat == L - 1) begin
               if (exp_pkt < 64) pkt_last[exp_pkt] = cyc;
               last_hs_cyc = cyc;
               exp_pkt++;
               exp_beat = 0;
            end else begin
               exp_beat++;
            end
         end
         prev_stall = m_tvalid & ~m_tready;
         prev_data  = m_tdata;
         prev_keep  = m_tkeep;
         prev_last  = m_tlast;
         if (done_cyc >= 0 && cyc == done_cyc + 1) begin
            idle_after_done = ap_idle;
            done_after_done = ap_done;
         end
         if (ap_done) begin
            done_count++;
            done_cyc     = cyc;
            idle_at_done = ap_idle;
         end
         if (areset) begin
            exp_pkt = 0; exp_beat = 0; total_beats = 0; n_starts = 0; prev_stall = 1'b0;
         end
      end
   end

   task automatic start_run(input int n, input bit hold);
      @(negedge aclk);
      exp_pkt = 0; exp_beat = 0; total_beats = 0; n_starts = 0; done_count = 0; valid_seen = 0;
      done_cyc = -1; last_hs_cyc = -1; idle_after_done = 1'b0; done_after_done = 1'b1; idle_at_done = 1'b1;
      job_count = JW'(n);
      ap_start  = 1'b1;
      #2;
      go_cyc = cyc;
      if (!hold) begin
         @(negedge aclk);
         ap_start = 1'b0;
      end
   endtask

   task automatic wait_done(output bit ok);
      ok = 1'b0;
      for (int c = 0; c < 3000; c++) begin
         @(negedge aclk); #2;
         if (done_count > 0) begin ok = 1'b1; break; end
      end
      @(negedge aclk); #2;
   endtask

   task automatic test_reset();
      areset = 1'b1;
      repeat (3) @(negedge aclk);
      #2;
      n_checks++; if (ap_idle !== 1'b1) begin n_fail++; $display("FAIL rst_idle: got %b want 1", ap_idle); end
      n_checks++; if (ap_done !== 1'b0) begin n_fail++; $display("FAIL rst_done: got %b want 0", ap_done); end
      n_checks++; if (src_start !== '0) begin n_fail++; $display("FAIL rst_src_start: got %b want 0", src_start); end
      n_checks++; if (s_tready !== '0) begin n_fail++; $display("FAIL rst_s_tready: got %b want 0", s_tready); end
      n_checks++;
      if (m_tvalid !== 1'b0 || m_tdata !== '0 || m_tkeep !== '0 || m_tlast !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_master: got valid=%b data=%h keep=%h last=%b want all zero", m_tvalid, m_tdata, m_tkeep, m_tlast);
      end
`ifdef STREAM_SCHED_STALL_CNT_EN
      n_checks++; if (stall_count !== 32'd0) begin n_fail++; $display("FAIL rst_stall: got %0d want 0", stall_count); end
`endif
      @(negedge aclk);
      areset = 1'b0;
      repeat (2) @(negedge aclk);
   endtask

   task automatic test_basic();
      bit ok;
      start_run(4, 1'b0);
      wait_done(ok);
      n_checks++; if (!ok) begin n_fail++; $display("FAIL basic_timeout: no ap_done within bound"); end
      n_checks++; if (n_starts !== 4) begin n_fail++; $display("FAIL basic_starts: got %0d want 4", n_starts); end
      n_checks++; if (total_beats !== 16) begin n_fail++; $display("FAIL basic_beats: got %0d want 16", total_beats); end
      n_checks++; if (done_count !== 1) begin n_fail++; $display("FAIL basic_done_pulses: got %0d want 1", done_count); end
      n_checks++;
      if (done_cyc !== last_hs_cyc + 1) begin
         n_fail++; $display("FAIL basic_done_timing: done at %0d want %0d", done_cyc, last_hs_cyc + 1);
      end
      for (int k = 0; k < 3; k++) begin
         n_checks++;
         if (pkt_first[k+1] !== pkt_last[k] + 2) begin
            n_fail++;
            $display("FAIL basic_bubble: pkt %0d starts at %0d want %0d", k + 1, pkt_first[k+1], pkt_last[k] + 2);
         end
      end
   endtask

   task automatic test_zero_jobs();
      bit ok;
      start_run(0, 1'b0);
      wait_done(ok);
      n_checks++; if (!ok) begin n_fail++; $display("FAIL zero_timeout: no ap_done within bound"); end
      n_checks++;
      if (done_cyc !== go_cyc + 1) begin
         n_fail++; $display("FAIL zero_done_timing: done at %0d want %0d", done_cyc, go_cyc + 1);
      end
      n_checks++; if (n_starts !== 0) begin n_fail++; $display("FAIL zero_starts: got %0d want 0", n_starts); end
      n_checks++; if (valid_seen !== 0) begin n_fail++; $display("FAIL zero_valid: got %0d cycles want 0", valid_seen); end
      n_checks++; if (done_count !== 1) begin n_fail++; $display("FAIL zero_done_pulses: got %0d want 1", done_count); end
   endtask

   task automatic test_three_jobs();
      bit ok;
      start_run(3, 1'b0);
      wait_done(ok);
      n_checks++; if (!ok) begin n_fail++; $display("FAIL three_timeout: no ap_done within bound"); end
      n_checks++; if (n_starts !== 3) begin n_fail++; $display("FAIL three_starts: got %0d want 3", n_starts); end
      n_checks++; if (exp_pkt !== 3) begin n_fail++; $display("FAIL three_completed: got %0d want 3", exp_pkt); end
      n_checks++; if (idle_at_done !== 1'b0) begin n_fail++; $display("FAIL three_idle_in_done: got %b want 0", idle_at_done); end
      n_checks++;
      if (idle_after_done !== 1'b1 || done_after_done !== 1'b0) begin
         n_fail++;
         $display("FAIL three_after_done: idle=%b done=%b want idle=1 done=0", idle_after_done, done_after_done);
      end
   endtask

   task automatic test_random_ready();
      bit ok;
      int n;
      rand_ready = 1'b1;
      for (int r = 0; r < 2; r++) begin
         n = (r == 0) ? 6 : $urandom_range(1, 7);
         start_run(n, 1'b0);
         wait_done(ok);
         n_checks++; if (!ok) begin n_fail++; $display("FAIL rand_timeout: run %0d no ap_done within bound", r); end
         n_checks++;
         if (total_beats !== n * L) begin
            n_fail++; $display("FAIL rand_beats: run %0d got %0d want %0d", r, total_beats, n * L);
         end
         n_checks++;
         if (done_cyc !== last_hs_cyc + 1) begin
            n_fail++; $display("FAIL rand_done_timing: done at %0d want %0d", done_cyc, last_hs_cyc + 1);
         end
      end
      rand_ready = 1'b0;
   endtask

   task automatic test_mid_reset();
      bit ok;
      start_run(4, 1'b0);
      ok = 1'b0;
      for (int c = 0; c < 500; c++) begin
         @(negedge aclk); #2;
         if (total_beats == 2) begin ok = 1'b1; break; end
      end
      n_checks++; if (!ok) begin n_fail++; $display("FAIL mrst_reach_beat2: got %0d beats want 2", total_beats); end
      @(negedge aclk);
      areset = 1'b1;
      @(negedge aclk);
      areset = 1'b0;
      #2;
      n_checks++; if (m_tvalid !== 1'b0) begin n_fail++; $display("FAIL mrst_valid: got %b want 0", m_tvalid); end
      n_checks++; if (src_start !== '0) begin n_fail++; $display("FAIL mrst_src_start: got %b want 0", src_start); end
      n_checks++; if (ap_idle !== 1'b1) begin n_fail++; $display("FAIL mrst_idle: got %b want 1", ap_idle); end
      start_run(2, 1'b0);
      wait_done(ok);
      n_checks++; if (!ok) begin n_fail++; $display("FAIL mrst_timeout: no ap_done within bound"); end
      n_checks++; if (total_beats !== 2 * L) begin n_fail++; $display("FAIL mrst_beats: got %0d want %0d", total_beats, 2 * L); end
   endtask

   task automatic test_hold_start();
      bit ok;
      start_run(2, 1'b1);
      wait_done(ok);
      n_checks++; if (!ok) begin n_fail++; $display("FAIL hold_timeout: no ap_done within bound"); end
      repeat (100) @(negedge aclk);
      #2;
      n_checks++; if (n_starts !== 2) begin n_fail++; $display("FAIL hold_starts: got %0d want 2", n_starts); end
      n_checks++; if (done_count !== 1) begin n_fail++; $display("FAIL hold_done_pulses: got %0d want 1", done_count); end
      n_checks++; if (ap_idle !== 1'b1) begin n_fail++; $display("FAIL hold_idle: got %b want 1", ap_idle); end
      @(negedge aclk);
      ap_start = 1'b0;
   endtask

`ifdef STREAM_SCHED_STALL_CNT_EN
   task automatic test_stall_count();
      bit ok;
      stall_at = 2;
      start_run(4, 1'b0);
      wait_done(ok);
      n_checks++; if (!ok) begin n_fail++; $display("FAIL stall_timeout: no ap_done within bound"); end
      n_checks++; if (stall_count !== 32'd10) begin n_fail++; $display("FAIL stall_count: got %0d want 10", stall_count); end
      n_checks++; if (total_beats !== 16) begin n_fail++; $display("FAIL stall_beats: got %0d want 16", total_beats); end
   endtask
`endif

   initial begin
      salt = $urandom;
      test_reset();
      test_basic();
      test_zero_jobs();
      test_three_jobs();
      test_random_ready();
      test_mid_reset();
      test_hold_start();
`ifdef STREAM_SCHED_STALL_CNT_EN
      test_stall_count();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/stream_job_scheduler.md
Name: stream_job_scheduler

Overview:
- Sequences and shares C_NUM_SRC AXI4-Stream packet generators (ap_start-edge-triggered, one tlast-terminated packet per start) for a single kernel run.
- On a host start, issues job_count start pulses across the sources and arbitrates their streams round-robin, packet-atomic, onto one AXI4-Stream master.
- Pulses ap_done once all job_count packets have left the master port.
- Sits between the kernel control block and the write-side datapath.

Parameters:
C_NUM_SRC, 2, number of generator sources (2..8)
C_TDATA_WIDTH, 128, stream data width in bits (multiple of 8)
C_JOB_WIDTH, 16, width of job_count and internal job counters

Ports:
aclk  in  1  clock
areset  in  1  synchronous active-high reset
ap_start  in  1  run request; rising edge starts a run
job_count  in  C_JOB_WIDTH  packets to produce; sampled on the start edge
ap_idle  out  1  high in IDLE
ap_done  out  1  one-cycle pulse at run completion
src_start  out  C_NUM_SRC  per-source start pulse
s_axis_tvalid  in  C_NUM_SRC  source valid
s_axis_tready  out  C_NUM_SRC  source ready
s_axis_tdata  in  C_NUM_SRC*C_TDATA_WIDTH  source data; source i at [i*W +: W]
s_axis_tkeep  in  C_NUM_SRC*C_TDATA_WIDTH/8  source keep
s_axis_tlast  in  C_NUM_SRC  source last
m_axis_tvalid  out  1  master valid
m_axis_tready  in  1  master ready
m_axis_tdata  out  C_TDATA_WIDTH  master data
m_axis_tkeep  out  C_TDATA_WIDTH/8  master keep
m_axis_tlast  out  1  master last

Behaviour:
- Reset: clock aclk; reset areset, synchronous, active-high. After reset: state IDLE, ap_idle=1, ap_done=0, src_start=0, s_axis_tready=0, m_axis_tvalid/tdata/tkeep/tlast=0, all busy flags and counters cleared, grant unlocked, round-robin pointer = C_NUM_SRC-1 (first grant goes to source 0).
- go = ap_start & ~ap_start_r (registered edge detect). go is honoured only in IDLE; ignored in all other states.
- FSM IDLE: on go, latch job_count into jobs_total, clear issued and completed. If job_count==0, go to DONE; otherwise go to RUN.
- FSM RUN: issue starts and arbitrate packets. When completed==jobs_total, go to DONE.
- FSM DONE: ap_done=1 for exactly this one cycle, then IDLE.
- ap_done timing:
  - Nonzero job_count: ap_done rises the cycle after the final tlast handshake.
  - Zero job_count: ap_done rises the cycle after go.
- Start issue (RUN):
  - A source is eligible if: busy[i]=0, src_start[i] was 0 in the previous cycle, and issued<jobs_total.
  - The lowest-index eligible source gets src_start[i]=1 for one cycle (registered output).
  - In that same cycle: busy[i] set, issued increments. At most one start per cycle.
- busy[i] clears on the m_axis handshake of source i's tlast beat.
- Arbitration:
  - When unlocked in RUN, select the first source after the rr pointer (circular) with tvalid & busy. Register it as grant, lock, and update the pointer to it.
  - The locked grant takes effect in the next cycle.
  - Locked datapath is combinational: m_axis_* = source[grant]; s_axis_tready[grant] = m_axis_tready; all other treadys are 0.
  - Unlocked: m_axis_tvalid=0 and tdata/tkeep/tlast=0.
  - Unlock on the tlast handshake (tvalid & tready & tlast). This leaves exactly one bubble cycle between packets. Packets are never interleaved.
- tvalid from a non-busy source is ignored; its tready stays 0.
- completed increments on each master tlast handshake. All counters are C_JOB_WIDTH bits and never wrap, since issued ≤ jobs_total.
- AXIS rule: master tdata/tkeep/tlast are stable while tvalid is high and tready is low, by pass-through from a compliant source.
- Reset mid-run: all state returns to reset values on the next edge. Any in-flight packet is abandoned; the bench must reset the sources too.
- ap_start held high across the end of a run produces no new run; a fresh rising edge is required.

Optional Feature:
- Macro STREAM_SCHED_STALL_CNT_EN.
- Defined: adds output port stall_count, 32 bits. It counts cycles in RUN with m_axis_tvalid & ~m_axis_tready, saturates at all-ones, is cleared on go and on areset, and holds its value after DONE.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- C_NUM_SRC=2, job_count=4, generators of 4-beat packets, tready=1: src_start pulses 0,1,0,1; master carries 16 beats as packets from sources 0,1,0,1 with one bubble between packets; ap_done a single pulse one cycle after the 16th beat.
- job_count=0: ap_done high exactly one cycle after the go cycle; no src_start pulses; m_axis_tvalid never asserted.
- job_count=3, 2 sources: exactly 3 start pulses (source 0 twice, source 1 once); completed reaches 3; ap_idle returns high the cycle after ap_done.
- Random tready (50% duty), job_count=6: all 24 beats emitted in order within each packet with no loss or duplication; tdata held steady whenever tready is low; no interleaving across tlast.
- areset asserted mid-packet during beat 2: next cycle m_axis_tvalid=0, src_start=0, ap_idle=1. A fresh run with job_count=2 then completes normally, first grant to source 0.
- ap_start held high for 100 cycles past ap_done: no second run. With STREAM_SCHED_STALL_CNT_EN and tready low for 10 cycles mid-run, stall_count=10 at ap_done.
